ex_div_unit: RTL and testbench

- Multi-cycle iterative integer divider for DIV/DIVU, instantiated beside the EX stage.
- It is the requesting side of the pipeline stall/flush controller:
  - raises `stallreq_o`, which drives the controller's `stallreq_from_ex` input, while a division is in flight;
  - obeys the controller's flush through `annul_i`.
- Produces `{remainder, quotient}` for the HI/LO write path.

---
 rtl/ex_div_unit.sv | 133 +++++++++++++
 tb/tb_ex_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU beside the EX stage.
// Holds the pipeline through stallreq_o until {remainder, quotient} is ready.
module ex_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StByZero, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     dvd_abs, dvs_abs;
    logic [2*WIDTH:0]     work_sh;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     quot, rem;

    always_comb begin
        dvd_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        dvs_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        // The partial remainder occupies work[2W-1:W]; after the shift it is W+1 bits wide.
        work_sh = {work_q, 1'b0};
        trial   = work_sh[2*WIDTH:WIDTH] - {1'b0, divisor_q};
        quot    = q_neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        rem     = r_neg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;

        unique case (state_q)
            StIdle: begin
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = StByZero;
                    end else begin
                        state_d   = StBusy;
                        cnt_d     = '0;
                        work_d    = {{WIDTH{1'b0}}, dvd_abs};
                        divisor_d = dvs_abs;
                        q_neg_d   = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        r_neg_d   = signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
            end
            StByZero: begin
                result_d = '0;
                state_d  = StDone;
            end
            StBusy: begin
                if (cnt_q != CntLast) begin
                    if (!trial[WIDTH]) begin
                        work_d = {trial[WIDTH-1:0], work_sh[WIDTH-1:1], 1'b1};
                    end else begin
                        work_d = work_sh[2*WIDTH-1:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d = {rem, quot};
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (!start_i) begin
                    state_d  = StIdle;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = StIdle;
                result_d = '0;
            end
        endcase

        // A flush wins over everything, including a completing division.
        if (annul_i) begin
            state_d  = StIdle;
            result_d = '0;
        end
    end

    always_comb begin
        ready_o    = (state_q == StDone);
        result_o   = result_q;
        stallreq_o = start_i && (state_q != StDone) && !annul_i;
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: driver queues expected results, monitor checks
// each rising ready_o against the queue head.
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    ex_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest queued result.
    initial begin
        logic        ready_seen;
        logic [63:0] req;
        ready_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_o && !ready_seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready actual=%h required=none", result_o);
                end else begin
                    req = exp_q.pop_front();
                    if (result_o !== req) begin
                        errors++;
                        $display("FAIL result actual=%h required=%h", result_o, req);
                    end
                end
            end
            ready_seen = ready_o;
        end
    end

    // Called from the cycle in which start_i is (or stays) high as cycle 0.
    task automatic wait_ready(input int exp_lat, input string name);
        int cyc;
        bit got;
        cyc = 0;
        got = 0;
        while (!got && cyc <= exp_lat + 8) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1;
            end else begin
                chk({name, "_stall_busy"}, 64'(stallreq_o), 64'd1);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, cyc, exp_lat);
        end else begin
            chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
            chk({name, "_stall_ready"}, 64'(stallreq_o), 64'd0);
        end
    endtask

    task automatic finish_div(input bit hold, input logic [63:0] req, input string name);
        if (hold) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({name, "_hold_ready"}, 64'(ready_o), 64'd1);
            chk({name, "_hold_result"}, result_o, req);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        chk({name, "_drop_ready"}, 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({name, "_idle_ready"}, 64'(ready_o), 64'd0);
        chk({name, "_idle_result"}, result_o, 64'd0);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] req, input int lat, input bit hold,
                           input string name);
        @(posedge clk);
        #1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        exp_q.push_back(req);
        wait_ready(lat, name);
        finish_div(hold, req, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b1, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0, "div_m7_2");
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, {32'h1, 32'h7FFF_FFFC}, 34, 1'b0, "divu_fff9_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34, 1'b0, "div_7_m2");
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE}, 34, 1'b0,
                "div_m100_m7");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 1'b0,
                "div_overflow");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34, 1'b0, "divu_max_1");
        run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b1, "divu_zero");
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 64'd0, 2, 1'b0, "div_zero");

        // Flush in cycle 10 of a division; nothing may complete afterwards.
        @(posedge clk);
        #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        #1;
        chk("annul_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (36) begin
                @(negedge clk);
                seen = seen | ready_o;
            end
            chk("annul_no_ready", 64'(seen), 64'd0);
        end
        run_div(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 1'b0, "divu_9_3");

        // Asynchronous reset in cycle 20 of a division, start_i held throughout.
        @(posedge clk);
        #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd33;
        start_i      = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("rst_busy_ready", 64'(ready_o), 64'd0);
        chk("rst_busy_result", result_o, 64'd0);
        chk("rst_busy_stall", 64'(stallreq_o), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back({32'hA, 32'h1E});
        wait_ready(34, "rst_restart");
        finish_div(1'b0, {32'hA, 32'h1E}, "rst_restart");

        // Asynchronous reset while a result is being presented.
        @(posedge clk);
        #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        exp_q.push_back({32'h2, 32'hE});
        wait_ready(34, "rst_done");
        #2;
        rst = 1'b0;
        #1;
        chk("rst_done_ready", 64'(ready_o), 64'd0);
        chk("rst_done_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
